param_lfsr: RTL and testbench
=============================

PARAM_LFSR -- requirements
Module: param_lfsr

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8: state and output width, legal range 3..32.
REQ-002 The block SHALL have parameter TAPS, default 8'hB8: feedback mask; TAPS[i]=1 taps state[i]; TAPS[WIDTH-1] SHALL be 1.
REQ-003 The block SHALL have parameter SEED, default 1: reset state and zero-seed substitute; SHALL be non-zero.
REQ-004 The block SHALL have parameter STEPS, default 1: shifts applied per enabled cycle, range 1..WIDTH.
REQ-005 The block SHALL have port clk  input  1: single clock; all state updates on the rising edge.
REQ-006 The block SHALL have port rst  input  1: reset, synchronous and active-high.
REQ-007 The block SHALL have port en  input  1: advance state by STEPS shifts this cycle.
REQ-008 The block SHALL have port load  input  1: load seed_in this cycle.
REQ-009 The block SHALL have port seed_in  input  WIDTH: seed value sampled when load=1.
REQ-010 The block SHALL have port rand_out  output  WIDTH: current state, driven directly from the state register.
REQ-011 The block SHALL have port rand_bit  output  1: equal to rand_out[0].
REQ-012 The block SHALL have port wrap  output  1: registered one-cycle pulse on period completion.
REQ-013 The block SHALL have port period  output  WIDTH: enabled-cycle count of the last completed period.
REQ-014 The block SHALL have port zero_seed  output  1: registered one-cycle pulse when an all-zero seed was substituted.

Function
REQ-015 One shift SHALL be: next = {s[WIDTH-2:0], ^(s & TAPS)} (Fibonacci, left shift, feedback into bit 0).
REQ-016 An enabled cycle SHALL apply the shift STEPS times combinationally and register the result in one clock; latency from en to rand_out SHALL be 1 cycle.
REQ-017 Priority SHALL be rst > load > en > hold; with en=0 and load=0, all registers SHALL hold.
REQ-018 On load with seed_in != 0: state and the internal start register SHALL take seed_in, the advance counter SHALL clear, and zero_seed SHALL be 0 next cycle.
REQ-019 On load with seed_in == 0: state and start SHALL take SEED, the counter SHALL clear, and zero_seed SHALL be 1 for exactly the next cycle.
REQ-020 load together with en SHALL perform only the load, with no advance and no counter increment.
REQ-021 On each enabled cycle the internal counter (WIDTH bits) SHALL increment, saturating at all-ones.
REQ-022 If the next state computed on an enabled cycle equals start: wrap SHALL be 1 in the following cycle, period SHALL be counter+1 (saturated), and the counter SHALL clear.
REQ-023 wrap SHALL be 0 in every cycle not covered by REQ-022; period SHALL hold its value until the next wrap or reset.
REQ-024 A load SHALL NOT change period.
REQ-025 State SHALL never become all-zero, given REQ-002, REQ-003 and REQ-019.

Reset
REQ-026 While rst=1 at a clock edge: state=SEED, start=SEED, counter=0, period=0, wrap=0, zero_seed=0.
REQ-027 rst asserted mid-run SHALL take effect at the next edge, overriding load and en in the same cycle.

Verification
REQ-028 WIDTH=4, TAPS=4'h9, SEED=4'h9, STEPS=1, en held after reset -> rand_out 9,2,4,8,1,3,7,F,E,...; after 15 enabled cycles rand_out=9, wrap=1 for one cycle, period=15.
REQ-029 Defaults, en held for 255 cycles after reset -> all 255 non-zero values visited once, wrap pulse after cycle 255, period=8'hFF; the next wrap occurs 255 cycles later.
REQ-030 load=1 with seed_in=0 -> next cycle rand_out=SEED, zero_seed=1 for one cycle; load with seed_in=8'h5A -> rand_out=8'h5A, zero_seed=0.
REQ-031 load=1 and en=1 in the same cycle with seed_in=4'h3 (4-bit config) -> rand_out=3 with no advance; the next wrap requires 15 further enabled cycles.
REQ-032 en toggled 0/1 irregularly, then rst mid-sequence -> state holds on en=0 cycles; after rst, rand_out=SEED, period=0, wrap=0.
REQ-033 4-bit config with STEPS=2, en held -> rand_out 9,4,1,7,E,...; wrap after 15 enabled cycles, period=15.

Source files
------------

// File: rtl/param_lfsr_if.sv
// Control and observation bundle for param_lfsr: the driver side sets en/load/seed_in,
// the LFSR side returns its state, wrap/period statistics and the zero-seed flag.
interface param_lfsr_if #(
  parameter int unsigned WIDTH = 8
) ();
  logic             en;
  logic             load;
  logic [WIDTH-1:0] seed_in;
  logic [WIDTH-1:0] rand_out;
  logic             rand_bit;
  logic             wrap;
  logic [WIDTH-1:0] period;
  logic             zero_seed;

  modport master (
    output en,
    output load,
    output seed_in,
    input  rand_out,
    input  rand_bit,
    input  wrap,
    input  period,
    input  zero_seed
  );

  modport slave (
    input  en,
    input  load,
    input  seed_in,
    output rand_out,
    output rand_bit,
    output wrap,
    output period,
    output zero_seed
  );
endinterface

// File: rtl/param_lfsr.sv
// Parameterised Fibonacci LFSR advancing STEPS shifts per enabled cycle, with period
// measurement against the last loaded/reset start value and all-zero seed substitution.
module param_lfsr #(
  parameter int unsigned      WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS  = 8'hB8,
  parameter logic [WIDTH-1:0] SEED  = 8'd1,
  parameter int unsigned      STEPS = 1
) (
  input logic         clk,
  input logic         rst,
  param_lfsr_if.slave bus
);

  logic [WIDTH-1:0] state_q, state_d;
  logic [WIDTH-1:0] start_q, start_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic             wrap_q, wrap_d;
  logic             zero_seed_q, zero_seed_d;

  logic [WIDTH-1:0] adv;
  logic [WIDTH-1:0] cnt_inc;
  logic             hit;

  // STEPS chained single shifts, unrolled into one combinational stage.
  always_comb begin
    adv = state_q;
    for (int unsigned i = 0; i < STEPS; i++) begin
      adv = {adv[WIDTH-2:0], ^(adv & TAPS)};
    end
  end

  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
  assign hit     = (adv == start_q);

  always_comb begin
    state_d     = state_q;
    start_d     = start_q;
    cnt_d       = cnt_q;
    period_d    = period_q;
    wrap_d      = 1'b0;
    zero_seed_d = 1'b0;
    if (bus.load) begin
      // An all-zero seed would lock the register, so SEED stands in for it.
      if (bus.seed_in == '0) begin
        state_d     = SEED;
        start_d     = SEED;
        zero_seed_d = 1'b1;
      end else begin
        state_d = bus.seed_in;
        start_d = bus.seed_in;
      end
      cnt_d = '0;
    end else if (bus.en) begin
      state_d = adv;
      if (hit) begin
        wrap_d   = 1'b1;
        period_d = cnt_inc;
        cnt_d    = '0;
      end else begin
        cnt_d = cnt_inc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= SEED;
      start_q     <= SEED;
      cnt_q       <= '0;
      period_q    <= '0;
      wrap_q      <= 1'b0;
      zero_seed_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      start_q     <= start_d;
      cnt_q       <= cnt_d;
      period_q    <= period_d;
      wrap_q      <= wrap_d;
      zero_seed_q <= zero_seed_d;
    end
  end

  assign bus.rand_out  = state_q;
  assign bus.rand_bit  = state_q[0];
  assign bus.wrap      = wrap_q;
  assign bus.period    = period_q;
  assign bus.zero_seed = zero_seed_q;

endmodule

// File: tb/tb_param_lfsr.sv
// Bench for param_lfsr: three configurations (4-bit x1, default 8-bit, 4-bit x2) checked
// every cycle against an arithmetic reference model plus directed expected sequences.
module tb_param_lfsr;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        en_v   [3];
  logic        load_v [3];
  logic [31:0] seed_v [3];

  logic [31:0] ro [3];
  logic [31:0] pr [3];
  logic        rb [3];
  logic        wr [3];
  logic        zs [3];

  int          w_c  [3] = '{4, 8, 4};
  logic [31:0] tp_c [3] = '{32'h9, 32'hB8, 32'h9};
  logic [31:0] sd_c [3] = '{32'h9, 32'h1, 32'h9};
  int          st_c [3] = '{1, 1, 2};

  logic [31:0] m_state [3];
  logic [31:0] m_start [3];
  logic [31:0] m_cnt   [3];
  logic [31:0] m_per   [3];
  logic        m_wrap  [3];
  logic        m_zs    [3];

  int n_checks = 0;
  int n_fails  = 0;

  param_lfsr_if #(.WIDTH(4)) b0 ();
  param_lfsr_if #(.WIDTH(8)) b1 ();
  param_lfsr_if #(.WIDTH(4)) b2 ();

  param_lfsr #(.WIDTH(4), .TAPS(4'h9), .SEED(4'h9), .STEPS(1)) u0 (
    .clk(clk), .rst(rst), .bus(b0)
  );
  param_lfsr u1 (
    .clk(clk), .rst(rst), .bus(b1)
  );
  param_lfsr #(.WIDTH(4), .TAPS(4'h9), .SEED(4'h9), .STEPS(2)) u2 (
    .clk(clk), .rst(rst), .bus(b2)
  );

  assign b0.en = en_v[0];  assign b0.load = load_v[0];  assign b0.seed_in = seed_v[0][3:0];
  assign b1.en = en_v[1];  assign b1.load = load_v[1];  assign b1.seed_in = seed_v[1][7:0];
  assign b2.en = en_v[2];  assign b2.load = load_v[2];  assign b2.seed_in = seed_v[2][3:0];

  assign ro[0] = {28'b0, b0.rand_out};  assign pr[0] = {28'b0, b0.period};
  assign ro[1] = {24'b0, b1.rand_out};  assign pr[1] = {24'b0, b1.period};
  assign ro[2] = {28'b0, b2.rand_out};  assign pr[2] = {28'b0, b2.period};
  assign rb[0] = b0.rand_bit;  assign wr[0] = b0.wrap;  assign zs[0] = b0.zero_seed;
  assign rb[1] = b1.rand_bit;  assign wr[1] = b1.wrap;  assign zs[1] = b1.zero_seed;
  assign rb[2] = b2.rand_bit;  assign wr[2] = b2.wrap;  assign zs[2] = b2.zero_seed;

  function automatic logic [31:0] mask_of(input int w);
    return (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
  endfunction

  // Shift count applied as repeated multiply-by-two with parity feedback.
  function automatic logic [31:0] advance(input int c, input logic [31:0] s);
    logic [31:0] r;
    r = s;
    for (int k = 0; k < st_c[c]; k++) begin
      r = ((r << 1) | 32'($countones(r & tp_c[c]) & 1)) & mask_of(w_c[c]);
    end
    return r;
  endfunction

  task automatic model_edge(input int c);
    logic [31:0] nxt;
    logic [31:0] cn;
    m_wrap[c] = 1'b0;
    m_zs[c]   = 1'b0;
    if (rst) begin
      m_state[c] = sd_c[c];
      m_start[c] = sd_c[c];
      m_cnt[c]   = 0;
      m_per[c]   = 0;
    end else if (load_v[c]) begin
      if ((seed_v[c] & mask_of(w_c[c])) == 0) begin
        m_state[c] = sd_c[c];
        m_zs[c]    = 1'b1;
      end else begin
        m_state[c] = seed_v[c] & mask_of(w_c[c]);
      end
      m_start[c] = m_state[c];
      m_cnt[c]   = 0;
    end else if (en_v[c]) begin
      nxt = advance(c, m_state[c]);
      cn  = (m_cnt[c] == mask_of(w_c[c])) ? m_cnt[c] : m_cnt[c] + 1;
      if (nxt == m_start[c]) begin
        m_wrap[c] = 1'b1;
        m_per[c]  = cn;
        m_cnt[c]  = 0;
      end else begin
        m_cnt[c] = cn;
      end
      m_state[c] = nxt;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("c%0d rand_out", c), ro[c], m_state[c]);
      chk($sformatf("c%0d rand_bit", c), {31'b0, rb[c]}, {31'b0, m_state[c][0]});
      chk($sformatf("c%0d wrap", c), {31'b0, wr[c]}, {31'b0, m_wrap[c]});
      chk($sformatf("c%0d period", c), pr[c], m_per[c]);
      chk($sformatf("c%0d zero_seed", c), {31'b0, zs[c]}, {31'b0, m_zs[c]});
    end
  endtask

  task automatic tick();
    @(posedge clk);
    for (int c = 0; c < 3; c++) model_edge(c);
    #1;
    check_all();
  endtask

  logic [31:0] seq0 [9] = '{32'h9, 32'h2, 32'h4, 32'h8, 32'h1, 32'h3, 32'h7, 32'hF, 32'hE};
  logic [31:0] seq2 [5] = '{32'h9, 32'h4, 32'h1, 32'h7, 32'hE};
  bit          seen [256];
  logic [31:0] prev [3];
  bit          en_pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

  initial begin
    int n;
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      en_v[c] = 1'b0;  load_v[c] = 1'b0;  seed_v[c] = 32'h0;
    end
    for (int v = 0; v < 256; v++) seen[v] = 1'b0;

    // Reset state, with en/load active to confirm reset priority.
    tick();
    for (int c = 0; c < 3; c++) begin
      en_v[c] = 1'b1;  load_v[c] = 1'b1;  seed_v[c] = 32'h3;
    end
    tick();
    chk("reset c0 rand_out", ro[0], 32'h9);
    chk("reset c1 rand_out", ro[1], 32'h1);
    chk("reset c1 period", pr[1], 32'h0);
    chk("reset c2 wrap", {31'b0, wr[2]}, 32'h0);

    // Free run: full periods for every configuration.
    rst = 1'b0;
    for (int c = 0; c < 3; c++) load_v[c] = 1'b0;
    for (int cyc = 1; cyc <= 510; cyc++) begin
      tick();
      if (cyc <= 8) chk("c0 sequence", ro[0], seq0[cyc]);
      if (cyc <= 4) chk("c2 sequence", ro[2], seq2[cyc]);
      if (cyc <= 255) seen[ro[1][7:0]] = 1'b1;
      if (cyc == 15) begin
        chk("c0 wrap at 15", {31'b0, wr[0]}, 32'h1);
        chk("c0 period 15", pr[0], 32'd15);
        chk("c0 back to seed", ro[0], 32'h9);
        chk("c2 wrap at 15", {31'b0, wr[2]}, 32'h1);
        chk("c2 period 15", pr[2], 32'd15);
      end
      if (cyc == 14) chk("c0 no early wrap", {31'b0, wr[0]}, 32'h0);
      if (cyc == 255) begin
        chk("c1 wrap at 255", {31'b0, wr[1]}, 32'h1);
        chk("c1 period ff", pr[1], 32'hFF);
        n = 0;
        for (int v = 1; v < 256; v++) if (seen[v]) n++;
        chk("c1 distinct states", n, 32'd255);
      end
      if (cyc == 509) chk("c1 no wrap at 509", {31'b0, wr[1]}, 32'h0);
      if (cyc == 510) chk("c1 second wrap", {31'b0, wr[1]}, 32'h1);
    end

    // Zero-seed substitution and normal load on the 8-bit instance.
    for (int c = 0; c < 3; c++) en_v[c] = 1'b0;
    load_v[1] = 1'b1;  seed_v[1] = 32'h0;
    tick();
    chk("zero load rand_out", ro[1], 32'h1);
    chk("zero load flag", {31'b0, zs[1]}, 32'h1);
    chk("load keeps period", pr[1], 32'hFF);
    load_v[1] = 1'b0;
    tick();
    chk("zero flag one cycle", {31'b0, zs[1]}, 32'h0);
    load_v[1] = 1'b1;  seed_v[1] = 32'h5A;
    tick();
    chk("load 5a rand_out", ro[1], 32'h5A);
    chk("load 5a flag", {31'b0, zs[1]}, 32'h0);
    load_v[1] = 1'b0;

    // load with en: load only, then a full period of enabled cycles.
    load_v[0] = 1'b1;  en_v[0] = 1'b1;  seed_v[0] = 32'h3;
    tick();
    chk("load+en no advance", ro[0], 32'h3);
    load_v[0] = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      tick();
      chk("reload wrap timing", {31'b0, wr[0]}, (k == 15) ? 32'h1 : 32'h0);
    end
    chk("reload period", pr[0], 32'd15);

    // Randomised traffic, including occasional reset and zero seeds.
    for (int cyc = 0; cyc < 400; cyc++) begin
      rst = ($urandom_range(0, 99) < 2);
      for (int c = 0; c < 3; c++) begin
        en_v[c]   = 1'($urandom_range(0, 1));
        load_v[c] = ($urandom_range(0, 19) == 0);
        seed_v[c] = ($urandom_range(0, 3) == 0) ? 32'h0 : ($urandom & mask_of(w_c[c]));
      end
      tick();
    end

    // Irregular enable with hold checks, then reset mid-sequence.
    rst = 1'b0;
    for (int c = 0; c < 3; c++) load_v[c] = 1'b0;
    for (int k = 0; k < 7; k++) begin
      for (int c = 0; c < 3; c++) begin
        en_v[c] = en_pat[k];
        prev[c] = ro[c];
      end
      tick();
      if (!en_pat[k]) begin
        for (int c = 0; c < 3; c++) chk($sformatf("c%0d hold", c), ro[c], prev[c]);
      end
    end
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      en_v[c] = 1'b1;  load_v[c] = 1'b1;  seed_v[c] = 32'h5;
    end
    tick();
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("c%0d mid rst rand_out", c), ro[c], sd_c[c]);
      chk($sformatf("c%0d mid rst period", c), pr[c], 32'h0);
      chk($sformatf("c%0d mid rst wrap", c), {31'b0, wr[c]}, 32'h0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
